// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: merges N valid/ready streams into one registered output.
// Whole packets are granted round-robin and never interleaved. A one-entry
// skid register lets the output stall without losing the beat in flight.
module rr_stream_arbiter #(
  parameter int N  = 4,
  parameter int DW = 32,
  localparam int IW = (N > 2) ? $clog2(N) : 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [N-1:0]    i_valid,
  input  logic [N*DW-1:0] i_data,
  input  logic [N-1:0]    i_last,
  output logic [N-1:0]    o_ready,
  output logic            o_valid,
  output logic [DW-1:0]   o_data,
  output logic            o_last,
  output logic [IW-1:0]   o_id,
  input  logic            i_ready
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t        state_q;
  logic [IW-1:0] g_q;
  logic [IW-1:0] ptr_q;
  logic          armed_q;

  logic          rdy_q, rdy_d;
  logic          vld_q, vld_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic [IW-1:0] id_q, id_d;
  logic          skid_vld_q, skid_vld_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          skid_last_q, skid_last_d;
  logic [IW-1:0] skid_id_q, skid_id_d;

  logic [DW-1:0] in_data [N];
  logic [IW-1:0] pick;
  logic          any_valid;
  logic          accept;
  logic          drain;
  logic [DW-1:0] beat_data;
  logic          beat_last;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign in_data[k] = i_data[k*DW +: DW];
  end

  assign accept    = (state_q == LOCK) && rdy_q && i_valid[g_q];
  assign drain     = vld_q && i_ready;
  assign beat_data = in_data[g_q];
  assign beat_last = i_last[g_q];

  // Round-robin search: lowest offset from ptr with a valid request wins.
  always_comb begin
    logic [IW:0] sum;
    pick      = ptr_q;
    any_valid = 1'b0;
    sum       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      if (i_valid[sum[IW-1:0]]) begin
        pick      = sum[IW-1:0];
        any_valid = 1'b1;
      end
    end
  end

  // Grant decode: only the locked channel sees ready, and only while the skid is free.
  always_comb begin
    o_ready = '0;
    if ((state_q == LOCK) && rdy_q) o_ready[g_q] = 1'b1;
  end

  // Arbitration FSM; armed_q holds off the first grant for one edge after reset release.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (armed_q && any_valid) begin
            g_q     <= pick;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (accept && beat_last) begin
            state_q <= IDLE;
            ptr_q   <= (g_q == IW'(N - 1)) ? '0 : g_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Primary/skid steering: skid refills primary on drain; new beats take primary if it frees up.
  always_comb begin
    vld_d       = vld_q;
    data_d      = data_q;
    last_d      = last_q;
    id_d        = id_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    skid_id_d   = skid_id_q;
    if (skid_vld_q) begin
      if (drain) begin
        vld_d      = 1'b1;
        data_d     = skid_data_q;
        last_d     = skid_last_q;
        id_d       = skid_id_q;
        skid_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!vld_q || drain) begin
        vld_d  = 1'b1;
        data_d = beat_data;
        last_d = beat_last;
        id_d   = g_q;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = beat_data;
        skid_last_d = beat_last;
        skid_id_d   = g_q;
      end
    end else if (drain) begin
      vld_d = 1'b0;
    end
    rdy_d = !skid_vld_d;
  end

  // Output register and skid occupancy; the output beat itself clears on reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_q      <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      id_q       <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      vld_q      <= vld_d;
      data_q     <= data_d;
      last_q     <= last_d;
      id_q       <= id_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  // Skid payload is qualified by skid_vld_q, so it needs no reset.
  always_ff @(posedge i_clk) begin
    skid_data_q <= skid_data_d;
    skid_last_q <= skid_last_d;
    skid_id_q   <= skid_id_d;
  end

  assign o_valid = vld_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_id    = id_q;

endmodule

// File: doc/rr_stream_arbiter.md
RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesting input channels, range 2..16.
REQ-002 SHALL have parameter DW, default 32: data width per beat.
REQ-003 SHALL have derived width IW = max(1, ceil(log2 N)): channel-index width.
REQ-004 SHALL have port i_clk, input, 1 bit: single clock, all state updated on the rising edge.
REQ-005 SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port i_valid, input, N bits: per-channel beat valid.
REQ-007 SHALL have port i_data, input, N*DW bits: channel k occupies bits [k*DW +: DW].
REQ-008 SHALL have port i_last, input, N bits: per-channel end-of-packet marker.
REQ-009 SHALL have port o_ready, output, N bits: per-channel accept.
REQ-010 SHALL have port o_valid, output, 1 bit: output beat valid (registered).
REQ-011 SHALL have port o_data, output, DW bits: output beat data (registered).
REQ-012 SHALL have port o_last, output, 1 bit: output end-of-packet (registered).
REQ-013 SHALL have port o_id, output, IW bits: source channel of the current output beat (registered).
REQ-014 SHALL have port i_ready, input, 1 bit: downstream accept.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and LOCK.
REQ-016 SHALL search in IDLE from round-robin pointer ptr upward with wrap (ptr, ptr+1 .. N-1, 0 .. ptr-1); the first channel with i_valid high becomes grant g; FSM enters LOCK next cycle.
REQ-017 SHALL remain in IDLE while no i_valid bit is high, with ptr unchanged.
REQ-018 SHALL drive o_ready[k] = (state==LOCK) && (g==k) && rdy_r; every other bit 0; o_ready SHALL NOT depend combinationally on i_ready or i_valid.
REQ-019 SHALL accept a beat on channel g in any cycle where i_valid[g] && o_ready[g].
REQ-020 SHALL, when an accepted beat has i_last[g]=1, return the FSM to IDLE and set ptr = (g+1) mod N on that edge, with no grant in the same cycle (one input-side idle cycle between packets).
REQ-021 SHALL hold g constant during LOCK regardless of other channels' i_valid (packet-atomic, no interleaving).
REQ-022 SHALL hold data, last and id of each accepted beat in a primary output register plus one skid register.
REQ-023 SHALL load an accepted beat into the primary register when the primary register is empty or is being drained (o_valid && i_ready); otherwise it SHALL go to the skid register.
REQ-024 SHALL make rdy_r 0 on the edge after the skid fills, and 1 on the edge after the skid moves into the primary register.
REQ-025 SHALL move the skid into the primary register whenever the primary register drains.
REQ-026 SHALL give latency of exactly 1 cycle from acceptance to o_valid when the output is not stalled, and sustain 1 beat/cycle within a packet while i_ready=1.
REQ-027 SHALL hold o_valid, o_data, o_last and o_id stable while o_valid && !i_ready; no beat is ever dropped or duplicated.
REQ-028 SHALL, when a channel drops i_valid mid-packet, remain in LOCK on that channel indefinitely.

Reset
REQ-029 SHALL, while i_reset=1, asynchronously force o_valid=0, o_last=0, o_data=0, o_id=0, o_ready=0, state=IDLE, ptr=0, skid empty, rdy_r=1.
REQ-030 SHALL discard partial packets and skid contents on reset mid-operation; arbitration restarts from channel 0 after release.
REQ-031 SHALL assert no o_ready bit earlier than the second rising edge after i_reset deasserts.

Verification
REQ-032 SHALL cover: single channel 2, 3-beat packet A0,A1,A2(last), i_ready=1 -> o_data A0,A1,A2 on consecutive cycles, o_id=2, o_last only on A2, ptr=3 afterward.
REQ-033 SHALL cover: all 4 channels continuously valid with 1-beat packets from reset -> grant order 0,1,2,3,0, one idle input cycle between packets.
REQ-034 SHALL cover: channel 1 mid-packet while channel 0 asserts i_valid -> channel 0 gets no o_ready until channel 1's last beat is accepted.
REQ-035 SHALL cover: i_ready held 0 for 5 cycles mid-packet -> at most 2 beats accepted (primary + skid), then o_ready[g]=0; after i_ready=1, beats emerge in order with no loss.
REQ-036 SHALL cover: i_reset pulsed asynchronously (between clock edges) during LOCK with the skid full -> o_valid=0 and o_ready=0 immediately; the next arbitration starts from channel 0.
REQ-037 SHALL cover: random i_valid/i_ready traffic for 10k cycles -> per-channel scoreboard matches in order, and no packet interleaving is seen on o_id between o_last beats.
